// File: rtl/neuron_cfg_byte_feeder.sv
// neuron_cfg_byte_feeder
// Buffers 32-bit configuration words in a small FIFO and serialises each one
// LSB-first into a byte stream with a one-cycle load_data strobe per byte.
// Consecutive strobes are always GAP+1 cycles apart, across word boundaries too.

module neuron_cfg_byte_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP        = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_word,
    input  logic [1:0]                    in_nbytes,
    output logic [7:0]                    data,
    output logic                          load_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);
    localparam logic [AW-1:0] PTR_ZERO = (AW)'(0);
    // WAIT counts down from GAP-1 to 0, so the gap lasts exactly GAP cycles
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // FIFO entries hold {nbytes-1, word}
    logic [33:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;

    state_t        state_r;
    logic [31:0]   shift_r;
    logic [1:0]    rem_r;       // bytes still to emit after the current one
    logic [3:0]    gap_cnt_r;
    logic [7:0]    data_r;
    logic          load_r;

    logic          push_s;
    logic          pop_s;
    logic          fifo_empty_s;
    logic [33:0]   head_s;
    logic          slot_end_s;  // this edge closes the current byte slot

    // Next-byte selection shared by IDLE and the end of every byte slot
    state_t        adv_state_s;
    logic          adv_load_s;
    logic [7:0]    adv_data_s;
    logic [31:0]   adv_shift_s;
    logic [1:0]    adv_rem_s;

    assign fifo_empty_s = (count_r == CNT_ZERO);
    assign in_ready     = !rst && !flush && (count_r < DEPTH_C);
    assign push_s       = in_valid && in_ready;
    assign head_s       = mem_r[rd_ptr_r];

    assign data         = data_r;
    assign load_data    = load_r;
    assign fifo_count   = count_r;
    assign busy         = (count_r != CNT_ZERO) || (state_r != ST_IDLE);

    // Decide whether the current byte slot ends on this edge
    always_comb begin
        slot_end_s = 1'b0;
        case (state_r)
            ST_IDLE: slot_end_s = 1'b1;
            ST_EMIT: begin
                if (GAP == 0) begin
                    slot_end_s = 1'b1;
                end else begin
                    slot_end_s = 1'b0;
                end
            end
            ST_WAIT: slot_end_s = (gap_cnt_r == 4'd0);
            default: slot_end_s = 1'b0;
        endcase
    end

    // Pick the next byte: remaining bytes of this word first, then the FIFO head
    always_comb begin
        adv_state_s = ST_IDLE;
        adv_load_s  = 1'b0;
        adv_data_s  = data_r;
        adv_shift_s = shift_r;
        adv_rem_s   = 2'd0;
        pop_s       = 1'b0;
        if (rem_r != 2'd0) begin
            adv_state_s = ST_EMIT;
            adv_load_s  = 1'b1;
            adv_data_s  = shift_r[7:0];
            adv_shift_s = {8'h00, shift_r[31:8]};
            adv_rem_s   = rem_r - 2'd1;
        end else if (!fifo_empty_s) begin
            adv_state_s = ST_EMIT;
            adv_load_s  = 1'b1;
            adv_data_s  = head_s[7:0];
            adv_shift_s = {8'h00, head_s[31:8]};
            adv_rem_s   = head_s[33:32];
            pop_s       = slot_end_s;
        end else begin
            adv_state_s = ST_IDLE;
            adv_load_s  = 1'b0;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_nbytes, in_word};
        end
    end

    // FIFO pointers and occupancy; flush beats any push or pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Serialiser FSM with registered data/strobe outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= 32'h0000_0000;
            rem_r     <= 2'd0;
            gap_cnt_r <= 4'd0;
            data_r    <= 8'h00;
            load_r    <= 1'b0;
        end else if (flush) begin
            // data_r deliberately keeps the last byte
            state_r   <= ST_IDLE;
            rem_r     <= 2'd0;
            gap_cnt_r <= 4'd0;
            load_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_EMIT: begin
                    if (GAP == 0) begin
                        state_r <= adv_state_s;
                        load_r  <= adv_load_s;
                        data_r  <= adv_data_s;
                        shift_r <= adv_shift_s;
                        rem_r   <= adv_rem_s;
                    end else begin
                        state_r   <= ST_WAIT;
                        load_r    <= 1'b0;
                        gap_cnt_r <= GAP_LAST;
                    end
                end
                ST_WAIT: begin
                    if (gap_cnt_r == 4'd0) begin
                        state_r <= adv_state_s;
                        load_r  <= adv_load_s;
                        data_r  <= adv_data_s;
                        shift_r <= adv_shift_s;
                        rem_r   <= adv_rem_s;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                        load_r    <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    state_r <= adv_state_s;
                    load_r  <= adv_load_s;
                    data_r  <= adv_data_s;
                    shift_r <= adv_shift_s;
                    rem_r   <= adv_rem_s;
                end
                default: begin
                    state_r <= ST_IDLE;
                    load_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_cfg_byte_feeder.sv
// Self-checking bench for neuron_cfg_byte_feeder.
// A scheduling model predicts every strobe time/byte, FIFO occupancy and busy
// from acceptance times; directed tests add hand-computed literal checks.

module tb_neuron_cfg_byte_feeder;

    localparam int DEPTH = 8;
    localparam int GAPV  = 3;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid;
    logic [31:0] in_word;
    logic [1:0]  in_nbytes;
    logic        in_ready, load_data, busy;
    logic [7:0]  data;
    logic [3:0]  fifo_count;

    // GAP=0 instance for the back-to-back strobe case
    logic        v0, flush0;
    logic [31:0] w0;
    logic [1:0]  n0;
    logic        ready0, load0, busy0;
    logic [7:0]  data0;
    logic [3:0]  cnt0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int avail;
        int s;
        int bend;
    } wrec_t;

    wrec_t      m_words[$];
    int         m_st_cyc[$];
    logic [7:0] m_st_dat[$];
    int         m_prev_last;
    logic [7:0] m_data;
    int         m_cnt_prev;

    int         log_cyc[$];
    logic [7:0] log_dat[$];

    always #5 clk = ~clk;

    neuron_cfg_byte_feeder #(.FIFO_DEPTH(DEPTH), .GAP(GAPV)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_nbytes(in_nbytes), .data(data), .load_data(load_data),
        .busy(busy), .fifo_count(fifo_count)
    );

    neuron_cfg_byte_feeder #(.FIFO_DEPTH(DEPTH), .GAP(0)) u_dut_g0 (
        .clk(clk), .rst(rst), .flush(flush0), .in_valid(v0), .in_ready(ready0),
        .in_word(w0), .in_nbytes(n0), .data(data0), .load_data(load0),
        .busy(busy0), .fifo_count(cnt0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Model and per-cycle compare
    initial begin : model
        logic       s_rst, s_fl, s_v, s_rdy, bz, ld;
        logic [31:0] s_w;
        logic [1:0] s_n;
        int         start, nb, cnt;
        wrec_t      rec;
        m_prev_last = -1000;
        m_data      = 8'h00;
        m_cnt_prev  = 0;
        forever begin
            @(posedge clk);
            s_rst = rst; s_fl = flush; s_v = in_valid; s_w = in_word; s_n = in_nbytes;
            s_rdy = !s_rst && !s_fl && (m_cnt_prev < DEPTH);
            cyc++;
            if (s_rst || s_fl) begin
                m_words.delete(); m_st_cyc.delete(); m_st_dat.delete();
                m_prev_last = -1000;
                if (s_rst) m_data = 8'h00;
            end else if (s_v && s_rdy) begin
                nb    = int'(s_n) + 1;
                start = (cyc + 1 > m_prev_last + GAPV + 1) ? cyc + 1 : m_prev_last + GAPV + 1;
                for (int i = 0; i < nb; i++) begin
                    m_st_cyc.push_back(start + i * (GAPV + 1));
                    m_st_dat.push_back(s_w[8*i +: 8]);
                end
                m_prev_last = start + (nb - 1) * (GAPV + 1);
                rec.avail = cyc; rec.s = start; rec.bend = m_prev_last + GAPV;
                m_words.push_back(rec);
            end
            #1;
            while (m_words.size() > 0 && m_words[0].bend < cyc) void'(m_words.pop_front());
            cnt = 0; bz = 1'b0;
            foreach (m_words[i]) begin
                if (m_words[i].avail <= cyc && cyc < m_words[i].s) cnt++;
                if (m_words[i].avail <= cyc && cyc <= m_words[i].bend) bz = 1'b1;
            end
            ld = 1'b0;
            if (m_st_cyc.size() > 0 && m_st_cyc[0] == cyc) begin
                ld = 1'b1;
                m_data = m_st_dat[0];
                void'(m_st_cyc.pop_front());
                void'(m_st_dat.pop_front());
            end
            m_cnt_prev = cnt;
            check("load_data", 32'(load_data), 32'(ld));
            check("data", 32'(data), 32'(m_data));
            check("busy", 32'(busy), 32'(bz));
            check("fifo_count", 32'(fifo_count), 32'(cnt));
            check("in_ready", 32'(in_ready), 32'(!rst && !flush && (cnt < DEPTH)));
            if (load_data === 1'b1) begin
                log_cyc.push_back(cyc);
                log_dat.push_back(data);
            end
        end
    end

    // Offer a word from a negedge until accepted; leaves in_valid high
    task automatic push(input logic [31:0] w, input logic [1:0] n, output int acc);
        in_valid = 1'b1; in_word = w; in_nbytes = n; acc = -1;
        for (int t = 0; t < 500; t++) begin
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                acc = cyc;
                return;
            end
            @(negedge clk);
        end
        timeout("push");
    endtask

    task automatic wait_idle(output int fall);
        fall = -1;
        for (int t = 0; t < 1000; t++) begin
            if (!busy) begin
                fall = cyc;
                return;
            end
            @(negedge clk);
        end
        timeout("drain");
    endtask

    initial begin : stim
        int         acc, fall, acc10;
        logic       found;
        logic [7:0] exp3 [5];
        logic [7:0] exp6 [4];
        exp3 = '{8'h01, 8'h02, 8'h05, 8'h06, 8'hAF};
        exp6 = '{8'hAF, 8'h00, 8'h3F, 8'hFE};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_word = 32'hDEAD_BEEF; in_nbytes = 2'd3;
        v0 = 1'b0; w0 = 32'h0; n0 = 2'd0; flush0 = 1'b0;

        // 1: reset with in_valid high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_load", 32'(load_data), 32'h0);
        check("rst_data", 32'(data), 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'h1);
        @(negedge clk);

        // 2: single two-byte word
        log_cyc.delete(); log_dat.delete();
        push(32'h0000_38FF, 2'd1, acc);
        in_valid = 1'b0;
        wait_idle(fall);
        check("t2_nstrobes", 32'(log_dat.size()), 32'd2);
        if (log_dat.size() >= 2) begin
            check("t2_b0", 32'(log_dat[0]), 32'hFF);
            check("t2_b1", 32'(log_dat[1]), 32'h38);
            check("t2_latency", 32'(log_cyc[0] - acc), 32'd1);
            check("t2_spacing", 32'(log_cyc[1] - log_cyc[0]), 32'd4);
            check("t2_busy_fall", 32'(fall - log_cyc[1]), 32'd4);
        end
        check("t2_data_hold", 32'(data), 32'h38);

        // 3: back-to-back words
        log_cyc.delete(); log_dat.delete();
        push(32'h0605_0201, 2'd3, acc);
        push(32'h0000_00AF, 2'd0, acc);
        in_valid = 1'b0;
        wait_idle(fall);
        check("t3_nstrobes", 32'(log_dat.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_dat.size(); i++) begin
            check("t3_byte", 32'(log_dat[i]), 32'(exp3[i]));
            if (i > 0) check("t3_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd4);
        end

        // 4: fill the FIFO
        log_cyc.delete(); log_dat.delete();
        for (int i = 0; i < 9; i++) begin
            push({8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)}, 2'd3, acc);
        end
        check("t4_ready_full", 32'(in_ready), 32'h0);
        check("t4_count_full", 32'(fifo_count), 32'd8);
        push({8'd40, 8'd39, 8'd38, 8'd37}, 2'd3, acc10);
        in_valid = 1'b0;
        wait_idle(fall);
        check("t4_nbytes", 32'(log_dat.size()), 32'd40);
        for (int i = 0; i < log_dat.size(); i++) check("t4_order", 32'(log_dat[i]), 32'(i + 1));
        found = 1'b0;
        foreach (log_cyc[i]) if (log_cyc[i] == acc10 - 1) found = 1'b1;
        check("t4_accept_after_pop", 32'(found), 32'h1);

        // 5: flush mid-word with three words queued
        log_cyc.delete(); log_dat.delete();
        push(32'h1413_1211, 2'd3, acc);
        push(32'h2423_2221, 2'd3, acc);
        push(32'h3433_3231, 2'd3, acc);
        push(32'h4443_4241, 2'd3, acc);
        in_valid = 1'b0;
        check("t5_queued", 32'(fifo_count), 32'd3);
        for (int t = 0; t < 200 && log_dat.size() < 2; t++) @(negedge clk);
        if (log_dat.size() < 2) timeout("t5_second_strobe");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t5_count", 32'(fifo_count), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_data_kept", 32'(data), 32'h12);
        repeat (20) @(negedge clk);
        check("t5_no_more", 32'(log_dat.size()), 32'd2);
        push(32'h0000_A55A, 2'd1, acc);
        in_valid = 1'b0;
        wait_idle(fall);
        check("t5_after_n", 32'(log_dat.size()), 32'd4);
        if (log_dat.size() >= 4) begin
            check("t5_new_b0", 32'(log_dat[2]), 32'h5A);
            check("t5_new_b1", 32'(log_dat[3]), 32'hA5);
            check("t5_new_latency", 32'(log_cyc[2] - acc), 32'd1);
        end

        // 6: GAP=0 instance emits four consecutive strobes
        v0 = 1'b1; w0 = 32'hFE3F_00AF; n0 = 2'd3;
        check("t6_ready", 32'(ready0), 32'h1);
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (j >= 1 && j <= 4) begin
                check("t6_load", 32'(load0), 32'h1);
                check("t6_data", 32'(data0), 32'(exp6[j-1]));
            end else begin
                check("t6_load_low", 32'(load0), 32'h0);
            end
            @(negedge clk);
        end
        check("t6_busy_end", 32'(busy0), 32'h0);
        check("t6_data_hold", 32'(data0), 32'hFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
